// File: rtl/arb_mux2_pkg.sv
// ---------------------------------------------------------------------------
// arb_mux2_pkg
//   Shared definitions for the two-channel packet merger: the arbiter state
//   encoding, the channel select codes carried on outSel, and the default
//   channel data width.
// ---------------------------------------------------------------------------
package arb_mux2_pkg;

    localparam int DATA_WIDTH = 16;

    // Merger state: IDLE arbitrates, LOCK_x holds the output for channel x
    // until that channel delivers its last beat.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    // Channel codes; also the outSel value seen by a downstream demux.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : arb_mux2_pkg

// File: rtl/arb_mux2_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin packet arbiter used by arb_mux2 while it is IDLE.
//   A lone requester always wins; on a tie the channel that did not finish
//   the most recent packet wins. The history bit only moves when a packet
//   actually completes, so a multi-beat packet counts as a single grant.
//
// Ports
//   clk        in   clock
//   resetN     in   synchronous active-low reset (tie goes to A afterwards)
//   validA/B   in   channel requests
//   beatDone   in   a last beat was accepted this cycle
//   beatSel    in   source of that accepted last beat (SEL_A / SEL_B)
//   grantValid out  at least one channel is requesting
//   grantSel   out  channel that would be granted (SEL_A / SEL_B)
// ---------------------------------------------------------------------------
module rr_arb2
    import arb_mux2_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic validA,
    input  logic validB,
    input  logic beatDone,
    input  logic beatSel,
    output logic grantValid,
    output logic grantSel
);

    // Source of the most recently completed packet.
    logic lastGrant;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        grantValid = validA || validB;
        grantSel   = SEL_A;
        if (validA && validB) begin
            grantSel = (lastGrant == SEL_B) ? SEL_A : SEL_B;
        end else if (validB) begin
            grantSel = SEL_B;
        end
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            // Pretend B finished last so the first tie goes to A.
            lastGrant <= SEL_B;
        end else if (beatDone) begin
            lastGrant <= beatSel;
        end
    end

endmodule : rr_arb2

// File: rtl/arb_mux2.sv
// ---------------------------------------------------------------------------
// arb_mux2
//   Merges two valid/ready packet streams (A and B) onto one output stream
//   without ever interleaving beats of different packets. Once a packet's
//   first beat is accepted the merger locks onto that channel until its last
//   beat. The output is a single-entry register: a beat accepted at one edge
//   appears on out the cycle after, and the register reloads in the same
//   cycle it drains, so back-to-back traffic runs at one beat per cycle.
//
// Ports
//   clk                 in   clock, all state on rising edge
//   resetN              in   synchronous active-low reset
//   inA/validA/lastA    in   channel A beat, valid, end-of-packet
//   readyA              out  channel A beat accepted when validA && readyA
//   inB/validB/lastB    in   channel B beat, valid, end-of-packet
//   readyB              out  channel B beat accepted when validB && readyB
//   out/outValid        out  merged beat and its valid
//   outLast             out  merged beat ends its packet
//   outSel              out  merged beat source (SEL_A / SEL_B)
//   outReady            in   consumer takes the beat when outValid && outReady
// ---------------------------------------------------------------------------
module arb_mux2
    import arb_mux2_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             resetN,

    input  logic [WIDTH-1:0] inA,
    input  logic             validA,
    input  logic             lastA,
    output logic             readyA,

    input  logic [WIDTH-1:0] inB,
    input  logic             validB,
    input  logic             lastB,
    output logic             readyB,

    output logic [WIDTH-1:0] out,
    output logic             outValid,
    output logic             outLast,
    output logic             outSel,
    input  logic             outReady
);

    state_t state;

    logic grantValid;
    logic grantSel;
    logic canLoad;
    logic acceptA;
    logic acceptB;
    logic acceptAny;
    logic acceptSel;
    logic acceptLast;

    // The register can take a beat when it is empty or is being emptied now.
    assign canLoad = !(outValid && !outReady);

    assign acceptA    = validA && readyA;
    assign acceptB    = validB && readyB;
    assign acceptAny  = acceptA || acceptB;
    assign acceptSel  = acceptB ? SEL_B : SEL_A;
    assign acceptLast = acceptB ? lastB : lastA;

    rr_arb2 uArb (
        .clk        (clk),
        .resetN     (resetN),
        .validA     (validA),
        .validB     (validB),
        .beatDone   (acceptAny && acceptLast),
        .beatSel    (acceptSel),
        .grantValid (grantValid),
        .grantSel   (grantSel)
    );

    // Ready goes only to the granted channel, and only when the output
    // register has room; while locked the other channel is simply ignored.
    always_comb begin
        readyA = 1'b0;
        readyB = 1'b0;
        if (resetN && canLoad) begin
            unique case (state)
                IDLE: begin
                    if (grantValid) begin
                        readyA = (grantSel == SEL_A);
                        readyB = (grantSel == SEL_B);
                    end
                end
                LOCK_A:  readyA = 1'b1;
                LOCK_B:  readyB = 1'b1;
                default: ;
            endcase
        end
    end

    // State and output register. A beat accepted with last=1 returns to IDLE
    // (also from IDLE itself); otherwise the merger locks on its source.
    // NOTE: reset is synchronous, so it lives inside the clocked block and is
    // only seen at a rising edge; ready is additionally gated while low.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= IDLE;
            out      <= '0;
            outValid <= 1'b0;
            outLast  <= 1'b0;
            outSel   <= SEL_A;
        end else begin
            if (acceptAny) begin
                out      <= acceptB ? inB : inA;
                outLast  <= acceptLast;
                outSel   <= acceptSel;
                outValid <= 1'b1;
                if (acceptLast) begin
                    state <= IDLE;
                end else begin
                    state <= acceptB ? LOCK_B : LOCK_A;
                end
            end else if (outReady) begin
                // Drained with nothing new; data fields keep their last value.
                outValid <= 1'b0;
            end
        end
    end

endmodule : arb_mux2

// File: tb/tb_arb_mux2.sv
module tb_arb_mux2;

    logic        clk;
    logic        resetN;
    logic [15:0] inA;
    logic        validA;
    logic        lastA;
    logic        readyA;
    logic [15:0] inB;
    logic        validB;
    logic        lastB;
    logic        readyB;
    logic [15:0] out;
    logic        outValid;
    logic        outLast;
    logic        outSel;
    logic        outReady;

    int checks = 0;
    int errors = 0;

    arb_mux2 #(.WIDTH(16)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .inA      (inA),
        .validA   (validA),
        .lastA    (lastA),
        .readyA   (readyA),
        .inB      (inB),
        .validB   (validB),
        .lastB    (lastB),
        .readyB   (readyB),
        .out      (out),
        .outValid (outValid),
        .outLast  (outLast),
        .outSel   (outSel),
        .outReady (outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at posedge+1; registered outputs are read at posedge+1,
    // combinational readies one time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vA, input logic lA, input logic [15:0] dA,
                         input logic vB, input logic lB, input logic [15:0] dB,
                         input logic oRdy);
        validA = vA; lastA = lA; inA = dA;
        validB = vB; lastB = lB; inB = dB;
        outReady = oRdy;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
        tick();
        resetN = 1'b1;
    endtask

    task automatic checkOut(input string name, input logic [15:0] d, input logic s, input logic l);
        check({name, ".outValid"}, 32'(outValid), 32'd1);
        check({name, ".out"},      32'(out),      32'(d));
        check({name, ".outSel"},   32'(outSel),   32'(s));
        check({name, ".outLast"},  32'(outLast),  32'(l));
    endtask

    // ---------------------------------------------------------------------
    // Directed vector table
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic        vA;
        logic        lA;
        logic [15:0] dA;
        logic        vB;
        logic        lB;
        logic [15:0] dB;
        logic        oRdy;
        logic        eRA;
        logic        eRB;
        logic        eV;
        logic [15:0] eD;
        logic        eS;
        logic        eL;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic vA, input logic lA, input logic [15:0] dA,
                                input logic vB, input logic lB, input logic [15:0] dB,
                                input logic oRdy, input logic eRA, input logic eRB,
                                input logic eV, input logic [15:0] eD,
                                input logic eS, input logic eL);
        vec_t v;
        v = '{vA, lA, dA, vB, lB, dB, oRdy, eRA, eRB, eV, eD, eS, eL};
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Random test reference: per-source FIFOs of accepted beats
    // ---------------------------------------------------------------------
    logic [16:0] qA [$];
    logic [16:0] qB [$];

    task automatic randomRun(input int cycles, input bit drain, inout int consumed);
        logic [15:0] curDA, curDB;
        logic        curLA, curLB;
        logic        pktOpen, openSrc;
        logic        accA, accB, cons;
        logic [18:0] expReg;
        logic [16:0] front;
        curDA = 16'($urandom); curLA = ($urandom_range(2) == 0);
        curDB = 16'($urandom); curLB = ($urandom_range(2) == 0);
        pktOpen = 1'b0; openSrc = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            validA = drain ? 1'b0 : ($urandom_range(99) < 60);
            validB = drain ? 1'b0 : ($urandom_range(99) < 60);
            inA = curDA; lastA = curLA;
            inB = curDB; lastB = curLB;
            outReady = drain ? 1'b1 : ($urandom_range(99) < 70);
            #1;
            check("oneReady", 32'(readyA && readyB), 32'd0);
            if (outValid && !outReady)
                check("stallNoReady", 32'(readyA || readyB), 32'd0);
            accA = validA && readyA;
            accB = validB && readyB;
            cons = outValid && outReady;
            if (cons) begin
                if (outSel) begin
                    check("sbNonEmptyB", 32'(qB.size() != 0), 32'd1);
                    if (qB.size() != 0) begin
                        front = qB.pop_front();
                        check("sbBeatB", 32'({outLast, out}), 32'(front));
                    end
                end else begin
                    check("sbNonEmptyA", 32'(qA.size() != 0), 32'd1);
                    if (qA.size() != 0) begin
                        front = qA.pop_front();
                        check("sbBeatA", 32'({outLast, out}), 32'(front));
                    end
                end
                if (pktOpen) check("noInterleave", 32'(outSel), 32'(openSrc));
                pktOpen = !outLast;
                openSrc = outSel;
                consumed++;
            end
            if (accA) begin
                qA.push_back({curLA, curDA});
                expReg = {1'b1, 1'b0, curLA, curDA};
                curDA = 16'($urandom); curLA = ($urandom_range(2) == 0);
            end
            if (accB) begin
                qB.push_back({curLB, curDB});
                expReg = {1'b1, 1'b1, curLB, curDB};
                curDB = 16'($urandom); curLB = ($urandom_range(2) == 0);
            end
            @(posedge clk);
            #1;
            if (accA || accB)
                check("latency1", 32'({outValid, outSel, outLast, out}), 32'(expReg));
        end
    endtask

    initial begin
        int consumed;
        resetN = 1'b0;
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
        tick();

        // ---- reset state ----
        doReset();
        check("reset.outValid", 32'(outValid), 32'd0);
        check("reset.out",      32'(out),      32'd0);
        check("reset.outLast",  32'(outLast),  32'd0);
        check("reset.outSel",   32'(outSel),   32'd0);

        // ---- table: alternation, A packet lock, B-only packet, drain ----
        tbl[0]  = mk(1, 1, 16'h000A, 1, 1, 16'h000B, 1,  1, 0,  1, 16'h000A, 0, 1);
        tbl[1]  = mk(1, 1, 16'h000A, 1, 1, 16'h000B, 1,  0, 1,  1, 16'h000B, 1, 1);
        tbl[2]  = mk(1, 1, 16'h000A, 1, 1, 16'h000B, 1,  1, 0,  1, 16'h000A, 0, 1);
        tbl[3]  = mk(1, 1, 16'h000A, 1, 1, 16'h000B, 1,  0, 1,  1, 16'h000B, 1, 1);
        tbl[4]  = mk(1, 0, 16'h0011, 1, 1, 16'h00B0, 1,  1, 0,  1, 16'h0011, 0, 0);
        tbl[5]  = mk(1, 0, 16'h0012, 1, 1, 16'h00B0, 1,  1, 0,  1, 16'h0012, 0, 0);
        tbl[6]  = mk(1, 1, 16'h0013, 1, 1, 16'h00B0, 1,  1, 0,  1, 16'h0013, 0, 1);
        tbl[7]  = mk(0, 0, 16'h0000, 1, 1, 16'h00B0, 1,  0, 1,  1, 16'h00B0, 1, 1);
        tbl[8]  = mk(0, 0, 16'h0000, 1, 0, 16'h00C1, 1,  0, 1,  1, 16'h00C1, 1, 0);
        tbl[9]  = mk(1, 1, 16'h00AA, 1, 1, 16'h00C2, 1,  0, 1,  1, 16'h00C2, 1, 1);
        tbl[10] = mk(1, 1, 16'h00AA, 0, 0, 16'h0000, 1,  1, 0,  1, 16'h00AA, 0, 1);
        tbl[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0,  0, 16'h0000, 0, 0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].vA, tbl[i].lA, tbl[i].dA, tbl[i].vB, tbl[i].lB, tbl[i].dB, tbl[i].oRdy);
            #1;
            check($sformatf("row%0d.readyA", i), 32'(readyA), 32'(tbl[i].eRA));
            check($sformatf("row%0d.readyB", i), 32'(readyB), 32'(tbl[i].eRB));
            tick();
            check($sformatf("row%0d.outValid", i), 32'(outValid), 32'(tbl[i].eV));
            if (tbl[i].eV)
                checkOut($sformatf("row%0d", i), tbl[i].eD, tbl[i].eS, tbl[i].eL);
        end

        // ---- stall: beat 0x55 held four cycles, then released ----
        doReset();
        drive(1, 1, 16'h0055, 0, 0, 16'h0, 0);
        #1;
        check("stall.load.readyA", 32'(readyA), 32'd1);
        tick();
        checkOut("stall.load", 16'h0055, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 16'h0066, 1, 1, 16'h00BB, 0);
            #1;
            check($sformatf("stall%0d.readyA", i), 32'(readyA), 32'd0);
            check($sformatf("stall%0d.readyB", i), 32'(readyB), 32'd0);
            tick();
            checkOut($sformatf("stall%0d", i), 16'h0055, 0, 1);
        end
        drive(1, 1, 16'h0066, 0, 0, 16'h0, 1);
        #1;
        check("release.readyA", 32'(readyA), 32'd1);
        tick();
        checkOut("release", 16'h0066, 0, 1);

        // ---- reset in the middle of an A packet ----
        doReset();
        drive(1, 1, 16'h0020, 0, 0, 16'h0, 1);   // A finishes a packet: A is now "last"
        tick();
        drive(1, 0, 16'h0021, 0, 0, 16'h0, 1);   // A opens a packet and locks
        tick();
        checkOut("midpkt", 16'h0021, 0, 0);
        resetN = 1'b0;
        drive(1, 0, 16'h0022, 1, 1, 16'h00B2, 1);
        #1;
        check("inReset.readyA", 32'(readyA), 32'd0);
        check("inReset.readyB", 32'(readyB), 32'd0);
        tick();
        resetN = 1'b1;
        check("postReset.outValid", 32'(outValid), 32'd0);
        drive(0, 0, 16'h0, 1, 1, 16'h00B3, 1);
        #1;
        check("postReset.lockGone", 32'(readyB), 32'd1);
        drive(1, 1, 16'h00A3, 1, 1, 16'h00B3, 1);
        #1;
        check("postReset.tieA.readyA", 32'(readyA), 32'd1);
        check("postReset.tieA.readyB", 32'(readyB), 32'd0);
        tick();
        checkOut("postReset.tie", 16'h00A3, 0, 1);

        // ---- randomized traffic against per-source scoreboard ----
        doReset();
        qA.delete();
        qB.delete();
        consumed = 0;
        randomRun(10000, 1'b0, consumed);
        randomRun(4, 1'b1, consumed);
        check("drain.qA", 32'(qA.size()), 32'd0);
        check("drain.qB", 32'(qB.size()), 32'd0);
        check("drain.outValid", 32'(outValid), 32'd0);
        check("progress", 32'(consumed > 2000), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_arb_mux2

// File: doc/arb_mux2.md
ARB_MUX2 -- requirements
Module: arb_mux2

Interface
REQ-001 WIDTH, 16, data width of each channel in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetN  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 inA  input  WIDTH  channel A data.
REQ-005 validA  input  1  channel A beat present.
REQ-006 lastA  input  1  channel A beat ends its packet.
REQ-007 readyA  output  1  channel A beat accepted when validA && readyA.
REQ-008 inB, validB, lastB, readyB  same widths/meaning as REQ-004..007 for channel B.
REQ-009 out  output  WIDTH  merged data.
REQ-010 outValid  output  1  out holds a beat.
REQ-011 outLast  output  1  beat ends its packet.
REQ-012 outSel  output  1  source of beat: 0 = A, 1 = B (select code for a downstream Demux).
REQ-013 outReady  input  1  consumer accepts beat when outValid && outReady.

Function
REQ-014 Block SHALL merge two valid/ready packet streams onto one, never interleaving beats of different packets.
REQ-015 State machine SHALL have states IDLE, LOCK_A, LOCK_B.
REQ-016 IDLE: only validA -> grant A; only validB -> grant B; both -> grant channel not granted last (lastGrant bit); neither -> stay IDLE.
REQ-017 Granted beat accepted in IDLE with last=0 SHALL move to LOCK_A/LOCK_B; with last=1 SHALL stay IDLE.
REQ-018 LOCK_x SHALL accept only channel x; accepted beat with last=1 SHALL return to IDLE; the other channel's valid SHALL be ignored.
REQ-019 lastGrant SHALL update on every accepted beat with last=1 to that beat's source.
REQ-020 Output SHALL be a single-entry register: out/outLast/outSel/outValid loaded on acceptance, latency exactly 1 cycle input-to-output.
REQ-021 Register SHALL load when empty or being drained in the same cycle (outValid && outReady), sustaining 1 beat/cycle.
REQ-022 readyA/readyB SHALL be combinational from state, lastGrant, valids and (outValid && !outReady); at most one ready SHALL be high per cycle.
REQ-023 readyx SHALL be 0 whenever channel x is not granted, including when register is full and not draining.
REQ-024 Held beat with outValid=1 and outReady=0 SHALL keep out/outLast/outSel stable until accepted.
REQ-025 Data SHALL pass unmodified; no width conversion.

Reset
REQ-026 On resetN=0 at rising edge: state=IDLE, lastGrant=1 (A wins first tie), outValid=0, out=0, outLast=0, outSel=0.
REQ-027 While resetN=0, readyA=readyB=0.
REQ-028 Reset mid-packet SHALL discard held beat and lock; no recovery of partial packet.

Structure
REQ-029 Shared package SHALL hold state encoding (IDLE=2'd0, LOCK_A=2'd1, LOCK_B=2'd2) and channel codes SEL_A=0, SEL_B=1.
REQ-030 Arbitration (REQ-016, REQ-019) SHALL be one sub-module rr_arb2; state machine and output register stay in arb_mux2.

Verification
REQ-031 After reset, validA=validB=1, lastA=lastB=1, outReady=1, inA=16'h000A, inB=16'h000B -> outputs alternate 000A/sel0, 000B/sel1, ... one beat per cycle, starting with A.
REQ-032 A sends 3-beat packet (0x11,0x12,0x13 last) while validB=1 -> three A beats contiguous, then B beat; readyB=0 during lock.
REQ-033 outReady=0 for 4 cycles with beat 0x55 held -> out=0x55, outValid=1 stable, readyA=readyB=0; release -> next beat next cycle.
REQ-034 Only validB asserted, 2-beat packet -> granted immediately despite lastGrant, outSel=1 both beats.
REQ-035 resetN=0 for one cycle mid-way through A packet -> outValid=0 next cycle, state IDLE, next tie granted to A.
REQ-036 Random valids/outReady, 10k cycles, scoreboard per source -> no lost, duplicated, reordered or interleaved beats.
